xdma_cfg_framer: RTL and testbench



---
 rtl/xdma_pkg.sv | 99 +++++++++
 rtl/xdma_cfg_framer.sv | 122 ++++++++++++
 tb/tb_xdma_cfg_framer.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xdma_pkg.sv
// ---------------------------------------------------------------------------
// xdma_pkg
// Shared constants and helpers for the inter-cluster XDMA cfg path.
//   - Default field widths / counts (the fixed 4-broadcast, 6-dimension layout)
//   - cfg_width(): total packed cfg width for arbitrary broadcast/dimension
//   - num_beats(), idx_width(): beat count and beat-index width helpers
//   - pack_cfg(): the canonical field order, LSB first
//   - frm_state_e: framer state encoding
// ---------------------------------------------------------------------------
package xdma_pkg;

  localparam int XdmaDataWidth   = 512;
  localparam int XdmaAddrWidth   = 48;
  localparam int XdmaIdWidth     = 8;
  localparam int XdmaStrideWidth = 19;
  localparam int XdmaBoundWidth  = 19;
  localparam int XdmaNrBroadcast = 4;
  localparam int XdmaNrDimension = 6;
  localparam int XdmaChanWidth   = 8;
  localparam int XdmaByteWidth   = 8;
  localparam int XdmaCntWidth    = 16;

  // Upper bounds accepted by pack_cfg(); the packed result is sized for them.
  localparam int XdmaMaxBroadcast = 16;
  localparam int XdmaMaxDimension = 16;

  typedef enum logic {
    FRM_IDLE = 1'b0,
    FRM_SEND = 1'b1
  } frm_state_e;

  function automatic int cfg_width(
    input int id_w,
    input int addr_w,
    input int stride_w,
    input int bound_w,
    input int nr_bc,
    input int nr_dim,
    input int chan_w,
    input int byte_w
  );
    return id_w + 1 + addr_w * (1 + nr_bc) + stride_w * (1 + nr_dim)
         + bound_w * nr_dim + chan_w + byte_w;
  endfunction

  function automatic int num_beats(input int cfg_w, input int data_w);
    return (cfg_w + data_w - 1) / data_w;
  endfunction

  // A single-beat frame still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int XdmaMaxCfgWidth = cfg_width(XdmaIdWidth, XdmaAddrWidth, XdmaStrideWidth,
                                             XdmaBoundWidth, XdmaMaxBroadcast,
                                             XdmaMaxDimension, XdmaChanWidth, XdmaByteWidth);

  // Packs the fields LSB first. Only the first nr_bc / nr_dim array entries
  // are used; the result occupies the low cfg_width(...) bits, rest zero.
  function automatic logic [XdmaMaxCfgWidth-1:0] pack_cfg(
    input int                                              nr_bc,
    input int                                              nr_dim,
    input logic [XdmaIdWidth-1:0]                          dma_id,
    input logic                                            dma_type,
    input logic [XdmaAddrWidth-1:0]                        reader_addr,
    input logic [XdmaMaxBroadcast-1:0][XdmaAddrWidth-1:0]  writer_addr,
    input logic [XdmaStrideWidth-1:0]                      spatial_stride,
    input logic [XdmaMaxDimension-1:0][XdmaBoundWidth-1:0] temporal_bound,
    input logic [XdmaMaxDimension-1:0][XdmaStrideWidth-1:0] temporal_stride,
    input logic [XdmaChanWidth-1:0]                        enable_channel,
    input logic [XdmaByteWidth-1:0]                        enable_byte
  );
    logic [XdmaMaxCfgWidth-1:0] res;
    int pos;
    res = '0;
    pos = 0;
    res[pos +: XdmaIdWidth] = dma_id;          pos += XdmaIdWidth;
    res[pos]                = dma_type;        pos += 1;
    res[pos +: XdmaAddrWidth] = reader_addr;   pos += XdmaAddrWidth;
    for (int i = 0; i < nr_bc; i++) begin
      res[pos +: XdmaAddrWidth] = writer_addr[i];
      pos += XdmaAddrWidth;
    end
    res[pos +: XdmaStrideWidth] = spatial_stride; pos += XdmaStrideWidth;
    for (int i = 0; i < nr_dim; i++) begin
      res[pos +: XdmaBoundWidth] = temporal_bound[i];
      pos += XdmaBoundWidth;
    end
    for (int i = 0; i < nr_dim; i++) begin
      res[pos +: XdmaStrideWidth] = temporal_stride[i];
      pos += XdmaStrideWidth;
    end
    res[pos +: XdmaChanWidth] = enable_channel; pos += XdmaChanWidth;
    res[pos +: XdmaByteWidth] = enable_byte;
    return res;
  endfunction

endpackage

// File: rtl/xdma_cfg_framer.sv
// ---------------------------------------------------------------------------
// xdma_cfg_framer
// Serialises one packed XDMA cfg into NumBeats DataWidth-bit beats for the
// to-remote cfg channel. The cfg is held zero-padded to NumBeats*DataWidth;
// beat k is bits [k*DataWidth +: DataWidth] of that padded image.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   cfg_i / cfg_valid_i /      cfg input handshake; ready is high in IDLE or
//   cfg_ready_o                while the last beat is being accepted
//   beat_o / beat_valid_o /    beat output stream
//   beat_ready_i
//   beat_idx_o, beat_last_o    beat index within frame, last-beat flag
//   busy_o                     a frame is held
//   frames_o                   completed-frame counter (wraps)
// ---------------------------------------------------------------------------
module xdma_cfg_framer
  import xdma_pkg::*;
#(
  parameter int DataWidth   = XdmaDataWidth,
  parameter int AddrWidth   = XdmaAddrWidth,
  parameter int IdWidth     = XdmaIdWidth,
  parameter int StrideWidth = XdmaStrideWidth,
  parameter int BoundWidth  = XdmaBoundWidth,
  parameter int NrBroadcast = XdmaNrBroadcast,
  parameter int NrDimension = XdmaNrDimension,
  parameter int ChanWidth   = XdmaChanWidth,
  parameter int ByteWidth   = XdmaByteWidth,
  parameter int CntWidth    = XdmaCntWidth,
  localparam int CfgWidth = cfg_width(IdWidth, AddrWidth, StrideWidth, BoundWidth,
                                      NrBroadcast, NrDimension, ChanWidth, ByteWidth),
  localparam int NumBeats = num_beats(CfgWidth, DataWidth),
  localparam int IdxWidth = idx_width(NumBeats)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [CfgWidth-1:0]  cfg_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  output logic [DataWidth-1:0] beat_o,
  output logic                 beat_valid_o,
  input  logic                 beat_ready_i,
  output logic [IdxWidth-1:0]  beat_idx_o,
  output logic                 beat_last_o,
  output logic                 busy_o,
  output logic [CntWidth-1:0]  frames_o
);

  localparam int PadWidth = NumBeats * DataWidth;
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumBeats - 1);

  frm_state_e          state_q, state_d;
  logic [CfgWidth-1:0] cfg_q, cfg_d;
  logic [IdxWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] frames_q, frames_d;

  logic [PadWidth-1:0] padded;
  logic [PadWidth-1:0] shifted;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= FRM_IDLE;
      cfg_q    <= '0;
      cnt_q    <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;

    beat_valid_o = (state_q == FRM_SEND);
    beat_last_o  = beat_valid_o && (cnt_q == LastIdx);
    // Accepting during the last-beat handshake lets frames run back to back.
    cfg_ready_o  = (state_q == FRM_IDLE) || (beat_last_o && beat_ready_i);

    case (state_q)
      FRM_IDLE: begin
        if (cfg_valid_i) begin
          state_d = FRM_SEND;
          cfg_d   = cfg_i;
          cnt_d   = '0;
        end
      end
      FRM_SEND: begin
        if (beat_ready_i) begin
          if (!beat_last_o) begin
            cnt_d = cnt_q + IdxWidth'(1);
          end else begin
            frames_d = frames_q + CntWidth'(1);
            if (cfg_valid_i) begin
              cfg_d = cfg_i;
              cnt_d = '0;
            end else begin
              state_d = FRM_IDLE;
            end
          end
        end
      end
      default: state_d = FRM_IDLE;
    endcase
  end

  // Zero-extension supplies the padding above the cfg; shifting the padded
  // image right by the beat offset is the k*DataWidth part-select.
  assign padded  = PadWidth'(cfg_q);
  assign shifted = padded >> (int'(cnt_q) * DataWidth);
  assign beat_o  = shifted[DataWidth-1:0];

  assign beat_idx_o = cnt_q;
  assign busy_o     = (state_q == FRM_SEND);
  assign frames_o   = frames_q;

endmodule

// File: tb/tb_xdma_cfg_framer.sv
module tb_xdma_cfg_framer;
  import xdma_pkg::*;

  typedef struct {
    logic [511:0] data;
    logic [0:0]   idx;
    logic         last;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults (CfgWidth 512, one beat)
  logic         a_rst_n, a_cfg_valid, a_cfg_ready, a_beat_valid, a_beat_ready;
  logic [511:0] a_cfg, a_beat;
  logic [0:0]   a_idx;
  logic         a_last, a_busy;
  logic [15:0]  a_frames;

  // Instance B: NrBroadcast=8 (CfgWidth 704, two beats)
  logic         b_rst_n, b_cfg_valid, b_cfg_ready, b_beat_valid, b_beat_ready;
  logic [703:0] b_cfg;
  logic [511:0] b_beat;
  logic [0:0]   b_idx;
  logic         b_last, b_busy;
  logic [15:0]  b_frames;

  // Instance C: CntWidth=2
  logic         c_rst_n, c_cfg_valid, c_cfg_ready, c_beat_valid, c_beat_ready;
  logic [511:0] c_cfg, c_beat;
  logic [0:0]   c_idx;
  logic         c_last, c_busy;
  logic [1:0]   c_frames;

  xdma_cfg_framer u_a (
    .clk_i(clk), .rst_ni(a_rst_n), .cfg_i(a_cfg), .cfg_valid_i(a_cfg_valid),
    .cfg_ready_o(a_cfg_ready), .beat_o(a_beat), .beat_valid_o(a_beat_valid),
    .beat_ready_i(a_beat_ready), .beat_idx_o(a_idx), .beat_last_o(a_last),
    .busy_o(a_busy), .frames_o(a_frames)
  );

  xdma_cfg_framer #(.NrBroadcast(8)) u_b (
    .clk_i(clk), .rst_ni(b_rst_n), .cfg_i(b_cfg), .cfg_valid_i(b_cfg_valid),
    .cfg_ready_o(b_cfg_ready), .beat_o(b_beat), .beat_valid_o(b_beat_valid),
    .beat_ready_i(b_beat_ready), .beat_idx_o(b_idx), .beat_last_o(b_last),
    .busy_o(b_busy), .frames_o(b_frames)
  );

  xdma_cfg_framer #(.CntWidth(2)) u_c (
    .clk_i(clk), .rst_ni(c_rst_n), .cfg_i(c_cfg), .cfg_valid_i(c_cfg_valid),
    .cfg_ready_o(c_cfg_ready), .beat_o(c_beat), .beat_valid_o(c_beat_valid),
    .beat_ready_i(c_beat_ready), .beat_idx_o(c_idx), .beat_last_o(c_last),
    .busy_o(c_busy), .frames_o(c_frames)
  );

  function automatic logic [XdmaMaxCfgWidth-1:0] make_cfg(input int nr_bc,
                                                           input logic [7:0] id,
                                                           input logic [47:0] raddr);
    logic [XdmaMaxBroadcast-1:0][47:0] wa;
    logic [XdmaMaxDimension-1:0][18:0] tbd;
    logic [XdmaMaxDimension-1:0][18:0] tst;
    for (int i = 0; i < XdmaMaxBroadcast; i++) wa[i] = 48'({$urandom, $urandom});
    for (int i = 0; i < XdmaMaxDimension; i++) begin
      tbd[i] = 19'($urandom);
      tst[i] = 19'($urandom);
    end
    return pack_cfg(nr_bc, 6, id, 1'($urandom), raddr, wa, 19'($urandom), tbd, tst,
                    8'($urandom), 8'($urandom));
  endfunction

  task automatic reset_a();
    @(negedge clk); a_rst_n = 1'b0; a_cfg_valid = 1'b0;
    @(negedge clk); a_rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic reset_b();
    @(negedge clk); b_rst_n = 1'b0; b_cfg_valid = 1'b0;
    @(negedge clk); b_rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks += 9;
    if (a_cfg_ready !== 1'b1)  begin errors++; $display("FAIL reset_cfg_ready got=%b exp=1", a_cfg_ready); end
    if (a_beat_valid !== 1'b0) begin errors++; $display("FAIL reset_beat_valid got=%b exp=0", a_beat_valid); end
    if (a_last !== 1'b0)       begin errors++; $display("FAIL reset_last got=%b exp=0", a_last); end
    if (a_idx !== 1'b0)        begin errors++; $display("FAIL reset_idx got=%0d exp=0", a_idx); end
    if (a_beat !== '0)         begin errors++; $display("FAIL reset_beat got=%h exp=0", a_beat); end
    if (a_busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b exp=0", a_busy); end
    if (a_frames !== 16'd0)    begin errors++; $display("FAIL reset_frames got=%0d exp=0", a_frames); end
    if (b_frames !== 16'd0)    begin errors++; $display("FAIL reset_b_frames got=%0d exp=0", b_frames); end
    if (c_frames !== 2'd0)     begin errors++; $display("FAIL reset_c_frames got=%0d exp=0", c_frames); end
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_single();
    beat_t e;
    reset_a();
    @(negedge clk);
    a_cfg = 512'(make_cfg(4, 8'h5A, 48'h1000_0000));
    a_cfg_valid = 1'b1; a_beat_ready = 1'b1;
    #1;
    checks++;
    if (a_cfg_ready !== 1'b1) begin errors++; $display("FAIL single_cfg_ready got=%b exp=1", a_cfg_ready); end
    exp_q.push_back('{data: a_cfg, idx: 1'b0, last: 1'b1});
    @(negedge clk); a_cfg_valid = 1'b0; #1;
    checks++;
    if (a_beat_valid !== 1'b1) begin
      errors++; $display("FAIL single_latency beat_valid got=%b exp=1", a_beat_valid);
    end else begin
      e = exp_q.pop_front();
      checks += 4;
      if (a_beat !== e.data)  begin errors++; $display("FAIL single_data got=%h exp=%h", a_beat, e.data); end
      if (a_idx !== e.idx)    begin errors++; $display("FAIL single_idx got=%0d exp=%0d", a_idx, e.idx); end
      if (a_last !== e.last)  begin errors++; $display("FAIL single_last got=%b exp=%b", a_last, e.last); end
      if (a_frames !== 16'd0) begin errors++; $display("FAIL single_frames_early got=%0d exp=0", a_frames); end
    end
    @(negedge clk); #1;
    checks += 3;
    if (a_frames !== 16'd1)    begin errors++; $display("FAIL single_frames got=%0d exp=1", a_frames); end
    if (a_busy !== 1'b0)       begin errors++; $display("FAIL single_busy_after got=%b exp=0", a_busy); end
    if (a_beat_valid !== 1'b0) begin errors++; $display("FAIL single_valid_after got=%b exp=0", a_beat_valid); end
    $display("test_single done frames=%0d", a_frames);
  endtask

  task automatic test_back_to_back();
    logic [511:0] cfgs [3];
    beat_t e;
    int sent = 0;
    int got = 0;
    reset_a();
    for (int i = 0; i < 3; i++) cfgs[i] = 512'(make_cfg(4, 8'(i + 1), 48'($urandom)));
    a_beat_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got < 3; cyc++) begin
      @(negedge clk);
      a_cfg_valid = (sent < 3);
      if (sent < 3) a_cfg = cfgs[sent];
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        checks++;
        if (a_beat_valid !== 1'b1) begin errors++; $display("FAIL b2b_bubble cyc=%0d got=%b exp=1", cyc, a_beat_valid); end
      end
      if (a_beat_valid && a_beat_ready && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks += 2;
        if (a_beat !== e.data) begin errors++; $display("FAIL b2b_data n=%0d got=%h exp=%h", got, a_beat, e.data); end
        if (a_last !== e.last) begin errors++; $display("FAIL b2b_last n=%0d got=%b exp=%b", got, a_last, e.last); end
        got++;
      end
      if (a_cfg_valid && a_cfg_ready) begin
        exp_q.push_back('{data: cfgs[sent], idx: 1'b0, last: 1'b1});
        sent++;
      end
    end
    a_cfg_valid = 1'b0;
    checks++;
    if (got != 3) begin errors++; $display("FAIL b2b_timeout got=%0d exp=3 beats", got); end
    @(negedge clk); #1;
    checks++;
    if (a_frames !== 16'd3) begin errors++; $display("FAIL b2b_frames got=%0d exp=3", a_frames); end
    $display("test_back_to_back done beats=%0d frames=%0d", got, a_frames);
  endtask

  task automatic push_b_frame(input logic [703:0] cfg);
    logic [1023:0] pad;
    pad = {320'b0, cfg};
    exp_q.push_back('{data: pad[511:0],    idx: 1'b0, last: 1'b0});
    exp_q.push_back('{data: pad[1023:512], idx: 1'b1, last: 1'b1});
  endtask

  task automatic test_two_beat();
    beat_t e;
    int got = 0;
    reset_b();
    @(negedge clk);
    b_cfg = 704'(make_cfg(8, 8'hC3, 48'($urandom)));
    b_cfg_valid = 1'b1; b_beat_ready = 1'b1;
    #1;
    if (b_cfg_ready) push_b_frame(b_cfg);
    for (int cyc = 0; cyc < 10 && got < 2; cyc++) begin
      @(negedge clk); b_cfg_valid = 1'b0; #1;
      if (b_beat_valid) begin
        e = exp_q.pop_front();
        checks += 4;
        if (b_beat !== e.data) begin errors++; $display("FAIL two_data n=%0d got=%h exp=%h", got, b_beat, e.data); end
        if (b_idx !== e.idx)   begin errors++; $display("FAIL two_idx n=%0d got=%0d exp=%0d", got, b_idx, e.idx); end
        if (b_last !== e.last) begin errors++; $display("FAIL two_last n=%0d got=%b exp=%b", got, b_last, e.last); end
        if (b_cfg_ready !== e.last) begin errors++; $display("FAIL two_cfg_ready n=%0d got=%b exp=%b", got, b_cfg_ready, e.last); end
        got++;
      end
    end
    checks++;
    if (got != 2) begin errors++; $display("FAIL two_timeout got=%0d exp=2 beats", got); end
    @(negedge clk); #1;
    checks++;
    if (b_frames !== 16'd1) begin errors++; $display("FAIL two_frames got=%0d exp=1", b_frames); end
    $display("test_two_beat done beats=%0d frames=%0d", got, b_frames);
  endtask

  task automatic test_backpressure();
    beat_t e;
    reset_b();
    @(negedge clk);
    b_cfg = 704'(make_cfg(8, 8'h11, 48'($urandom)));
    b_cfg_valid = 1'b1; b_beat_ready = 1'b1;
    #1;
    push_b_frame(b_cfg);
    @(negedge clk); b_cfg_valid = 1'b0; #1;
    e = exp_q.pop_front();
    checks++;
    if (b_beat !== e.data) begin errors++; $display("FAIL bp_beat0 got=%h exp=%h", b_beat, e.data); end
    e = exp_q.pop_front();
    @(negedge clk); b_beat_ready = 1'b0;
    b_cfg_valid = 1'b1; b_cfg = 704'(make_cfg(8, 8'h22, 48'($urandom)));
    for (int cyc = 0; cyc < 5; cyc++) begin
      #1;
      checks += 6;
      if (b_beat_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", cyc, b_beat_valid); end
      if (b_beat !== e.data)     begin errors++; $display("FAIL bp_data cyc=%0d got=%h exp=%h", cyc, b_beat, e.data); end
      if (b_idx !== 1'b1)        begin errors++; $display("FAIL bp_idx cyc=%0d got=%0d exp=1", cyc, b_idx); end
      if (b_last !== 1'b1)       begin errors++; $display("FAIL bp_last cyc=%0d got=%b exp=1", cyc, b_last); end
      if (b_cfg_ready !== 1'b0)  begin errors++; $display("FAIL bp_cfg_ready cyc=%0d got=%b exp=0", cyc, b_cfg_ready); end
      if (b_frames !== 16'd0)    begin errors++; $display("FAIL bp_frames cyc=%0d got=%0d exp=0", cyc, b_frames); end
      @(negedge clk);
    end
    b_cfg_valid = 1'b0; b_beat_ready = 1'b1;
    @(negedge clk); #1;
    checks += 2;
    if (b_frames !== 16'd1)    begin errors++; $display("FAIL bp_frames_done got=%0d exp=1", b_frames); end
    if (b_beat_valid !== 1'b0) begin errors++; $display("FAIL bp_idle got=%b exp=0", b_beat_valid); end
    $display("test_backpressure done frames=%0d", b_frames);
  endtask

  task automatic test_reset_mid_frame();
    beat_t e;
    reset_b();
    @(negedge clk);
    b_cfg = 704'(make_cfg(8, 8'h33, 48'($urandom)));
    b_cfg_valid = 1'b1; b_beat_ready = 1'b1;
    @(negedge clk); b_cfg_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (b_idx !== 1'b1) begin errors++; $display("FAIL mid_in_beat1 got=%0d exp=1", b_idx); end
    b_rst_n = 1'b0;
    #1;
    checks += 6;
    if (b_beat_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got=%b exp=0", b_beat_valid); end
    if (b_cfg_ready !== 1'b1)  begin errors++; $display("FAIL mid_cfg_ready got=%b exp=1", b_cfg_ready); end
    if (b_idx !== 1'b0)        begin errors++; $display("FAIL mid_idx got=%0d exp=0", b_idx); end
    if (b_beat !== '0)         begin errors++; $display("FAIL mid_beat got=%h exp=0", b_beat); end
    if (b_busy !== 1'b0)       begin errors++; $display("FAIL mid_busy got=%b exp=0", b_busy); end
    if (b_frames !== 16'd0)    begin errors++; $display("FAIL mid_frames got=%0d exp=0", b_frames); end
    @(negedge clk); b_rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    b_cfg = 704'(make_cfg(8, 8'h44, 48'($urandom)));
    b_cfg_valid = 1'b1;
    #1;
    push_b_frame(b_cfg);
    @(negedge clk); b_cfg_valid = 1'b0; #1;
    e = exp_q.pop_front();
    checks += 3;
    if (b_beat !== e.data) begin errors++; $display("FAIL mid_restart_data got=%h exp=%h", b_beat, e.data); end
    if (b_idx !== e.idx)   begin errors++; $display("FAIL mid_restart_idx got=%0d exp=%0d", b_idx, e.idx); end
    if (b_last !== e.last) begin errors++; $display("FAIL mid_restart_last got=%b exp=%b", b_last, e.last); end
    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (b_frames !== 16'd1) begin errors++; $display("FAIL mid_restart_frames got=%0d exp=1", b_frames); end
    exp_q.delete();
    $display("test_reset_mid_frame done frames=%0d", b_frames);
  endtask

  task automatic test_wrap();
    logic [1:0] exp_frames = 2'd0;
    beat_t e;
    c_beat_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      @(negedge clk);
      c_cfg = 512'(make_cfg(4, 8'(f), 48'($urandom)));
      c_cfg_valid = 1'b1;
      #1;
      if (c_cfg_ready) exp_q.push_back('{data: c_cfg, idx: 1'b0, last: 1'b1});
      @(negedge clk); c_cfg_valid = 1'b0; #1;
      checks++;
      if (c_beat_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++; $display("FAIL wrap_valid f=%0d got=%b exp=1", f, c_beat_valid);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (c_beat !== e.data) begin errors++; $display("FAIL wrap_data f=%0d got=%h exp=%h", f, c_beat, e.data); end
      end
      @(negedge clk); #1;
      exp_frames = exp_frames + 2'd1;
      checks++;
      if (c_frames !== exp_frames) begin errors++; $display("FAIL wrap_frames f=%0d got=%0d exp=%0d", f, c_frames, exp_frames); end
      $display("test_wrap frame %0d frames=%0d", f, c_frames);
    end
  endtask

  initial begin
    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    a_cfg = '0; b_cfg = '0; c_cfg = '0;
    a_cfg_valid = 1'b0; b_cfg_valid = 1'b0; c_cfg_valid = 1'b0;
    a_beat_ready = 1'b0; b_beat_ready = 1'b0; c_beat_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_two_beat();
    test_backpressure();
    test_reset_mid_frame();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
